// File: rtl/div_controller.sv
// Signed 32-bit restoring divider: 33-cycle latency (1 for divide-by-zero).
// No backpressure; a new start aborts any operation in flight.
module div_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Partial remainder always stays below |B| once a step completes, so it fits 32 bits.
  logic [31:0] p_q, p_d;
  logic [31:0] q_q, q_d;
  logic [31:0] b_q, b_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic [31:0] result_q, result_d;
  logic [31:0] rem_q, rem_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] p_shift;
  logic        no_borrow;

  assign abs_a     = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign abs_b     = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
  assign p_shift   = {p_q, q_q[31]};
  assign no_borrow = (p_shift >= {1'b0, b_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    q_d      = q_q;
    b_d      = b_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    rem_d    = rem_q;
    exc_d    = exc_q;
    rdy_d    = rdy_q;

    if (ctrl_DIV) begin
      b_d     = abs_b;
      q_d     = abs_a;
      p_d     = 32'd0;
      cnt_d   = 6'd0;
      qsign_d = data_operandA[31] ^ data_operandB[31];
      rsign_d = data_operandA[31];
      rdy_d   = 1'b0;
      exc_d   = 1'b0;
      if (data_operandB == 32'd0) begin
        state_d  = S_DONE;
        result_d = 32'd0;
        rem_d    = data_operandA;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          q_d   = {q_q[30:0], no_borrow};
          p_d   = no_borrow ? (p_shift[31:0] - b_q) : p_shift[31:0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = qsign_q ? (~q_q + 32'd1) : q_q;
          rem_d    = rsign_q ? (~p_q + 32'd1) : p_q;
          rdy_d    = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE:  rdy_d = 1'b0;
        default: rdy_d = 1'b0;
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      p_q      <= 32'd0;
      q_q      <= 32'd0;
      b_q      <= 32'd0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= 32'd0;
      rem_q    <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      q_q      <= q_d;
      b_q      <= b_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div_controller.sv
// Directed and random divides checked against a truncating-division reference model.
module tb_div_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div_controller dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes as unsigned, then apply C-style signs.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic e);
    logic [31:0] ua, ub, uq, ur;
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      q  = (a[31] ^ b[31]) ? -uq : uq;
      r  = a[31] ? -ur : ur;
      e  = 1'b0;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ee;
    model(a, b, eq, er, ee);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (b == 32'd0) begin
      chk("dz_rdy",    {31'd0, data_resultRDY}, 32'd1);
      chk("dz_exc",    {31'd0, data_exception}, 32'd1);
      chk("dz_busy",   {31'd0, busy}, 32'd0);
      chk("dz_result", data_result, eq);
      chk("dz_rem",    data_remainder, er);
      tick();
      chk("dz_rdy_fall", {31'd0, data_resultRDY}, 32'd0);
      chk("dz_exc_hold", {31'd0, data_exception}, 32'd1);
    end else begin
      chk("start_busy_rdy", {30'd0, busy, data_resultRDY}, 32'd2);
      for (int i = 1; i <= 32; i++) begin
        tick();
        chk("run_busy_rdy", {30'd0, busy, data_resultRDY}, 32'd2);
      end
      tick();
      chk("done_rdy",    {31'd0, data_resultRDY}, 32'd1);
      chk("done_busy",   {31'd0, busy}, 32'd0);
      chk("done_exc",    {31'd0, data_exception}, {31'd0, ee});
      chk("done_result", data_result, eq);
      chk("done_rem",    data_remainder, er);
      tick();
      chk("rdy_fall",    {31'd0, data_resultRDY}, 32'd0);
      chk("result_hold", data_result, eq);
      chk("rem_hold",    data_remainder, er);
    end
  endtask

  initial begin
    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_result", data_result, 32'd0);
    chk("rst_rem",    data_remainder, 32'd0);
    chk("rst_flags",  {29'd0, data_exception, data_resultRDY, busy}, 32'd0);

    run_div(32'd7, 32'd2);
    run_div(32'hFFFFFFF9, 32'd2);
    run_div(32'd7, 32'hFFFFFFFE);
    run_div(32'd5, 32'd0);
    run_div(32'h80000000, 32'hFFFFFFFF);
    run_div(32'hFFFFFFFF, 32'h80000000);
    run_div(32'h80000000, 32'h80000000);
    run_div(32'd0, 32'd9);

    // Restart at edge 10: only the second operation may strobe, after edge 43.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    for (int e = 11; e <= 42; e++) begin
      tick();
      chk("restart_no_rdy", {30'd0, busy, data_resultRDY}, 32'd2);
    end
    tick();
    chk("restart_rdy",    {31'd0, data_resultRDY}, 32'd1);
    chk("restart_result", data_result, 32'd10);
    chk("restart_rem",    data_remainder, 32'd0);
    tick();

    // Reset at edge 20 discards the operation.
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    for (int i = 1; i <= 19; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_rem",    data_remainder, 32'd0);
    chk("midrst_flags",  {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("midrst_no_rdy", {30'd0, busy, data_resultRDY}, 32'd0);
    end

    // Reset wins over a simultaneous start.
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    reset = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    reset = 1'b0;
    chk("rst_prio", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -$urandom_range(1, 20);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
